// File: rtl/mem_access_initiator.sv
// Load/store initiator for one data_memory_with_lock port: word-only mem_req, sub-word stores via locked read-modify-write.
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds TIMEOUT_CYCLES and done_timeout; rpl_req packs {req, issue_id}.
package mem_access_pkg;
  typedef struct packed {
    logic [29:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } mem_req_t;
endpackage

module mem_access_initiator
  import mem_access_pkg::*;
#(
  parameter int ID_WIDTH = 4
`ifdef MEM_ACCESS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [ID_WIDTH-1:0] op_id,
  input  logic [2:0]          op_type,
  input  logic [31:0]         op_addr,
  input  logic [31:0]         op_wdata,
  output logic [ID_WIDTH:0]   rpl_req,
  output mem_req_t            mem_req,
  input  logic                grant,
  input  logic [31:0]         rdata,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [ID_WIDTH-1:0] done_id,
  output logic [31:0]         done_rdata,
`ifdef MEM_ACCESS_TIMEOUT_EN
  output logic                done_timeout,
`endif
  output logic                done_err
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q;
  logic [2:0]          type_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         old_q;
  logic                accept;
  logic                misaligned;
  logic                timeout_hit;
  logic [4:0]          shamt;
  logic [31:0]         lane;
  logic [31:0]         load_ext;
  logic [31:0]         mask;
  logic [31:0]         merged;

  always_comb begin
    misaligned = 1'b0;
    case (op_type)
      OP_LH, OP_LHU, OP_SH: misaligned = op_addr[0];
      OP_LW, OP_SW:         misaligned = |op_addr[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Little-endian lane select for loads and byte/half merge for the RMW write.
  always_comb begin
    shamt = {addr_q[1:0], 3'b000};
    lane  = rdata >> shamt;
    case (type_q)
      OP_LB:   load_ext = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_ext = {24'h0, lane[7:0]};
      OP_LH:   load_ext = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = rdata;
    endcase
    mask   = ((type_q == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    merged = (old_q & ~mask) | ((wdata_q << shamt) & mask);
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  assign timeout_hit = ((state_q == REQ) || (state_q == WRITE)) && !grant &&
                       (int'(wait_cnt) >= TIMEOUT_CYCLES - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    op_ready   = 1'b0;
    accept     = 1'b0;
    rpl_req    = '0;
    mem_req    = '0;
    done_valid = 1'b0;
    case (state_q)
      IDLE: begin
        op_ready = !reset;
        accept   = op_valid && !reset;
        if (accept) state_d = misaligned ? DONE : REQ;
      end
      REQ: begin
        rpl_req      = {1'b1, id_q};
        mem_req.addr = addr_q[31:2];
        if (type_q == OP_SW) begin
          mem_req.wen   = 1'b1;
          mem_req.wdata = wdata_q;
        end
        if (grant) state_d = ((type_q == OP_SB) || (type_q == OP_SH)) ? WRITE : DONE;
        else if (timeout_hit) state_d = DONE;
      end
      WRITE: begin
        rpl_req       = {1'b1, id_q};
        mem_req.addr  = addr_q[31:2];
        mem_req.wen   = 1'b1;
        mem_req.wdata = merged;
        if (grant || timeout_hit) state_d = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result fields are loaded at accept and refined on grant, so they are stable throughout DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q       <= '0;
      type_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      done_id    <= '0;
      done_rdata <= '0;
      done_err   <= 1'b0;
    end else begin
      if (accept) begin
        id_q       <= op_id;
        type_q     <= op_type;
        addr_q     <= op_addr;
        wdata_q    <= op_wdata;
        done_id    <= op_id;
        done_rdata <= '0;
        done_err   <= misaligned;
      end
      if ((state_q == REQ) && grant) begin
        old_q <= rdata;
        if (type_q <= OP_LW) done_rdata <= load_ext;
      end
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      done_timeout <= 1'b0;
    end else begin
      if (accept) done_timeout <= 1'b0;
      else if (timeout_hit) done_timeout <= 1'b1;
      if ((state_d != state_q) && ((state_d == REQ) || (state_d == WRITE)))
        wait_cnt <= '0;
      else if (((state_q == REQ) || (state_q == WRITE)) && !grant)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end
`endif

endmodule
